// File: rtl/flush_seq_pkg.sv
// Shared types and helpers for the commit-stage flush sequencer.
package flush_seq_pkg;

  typedef enum logic [2:0] {
    KIND_FENCE    = 3'd0,
    KIND_FENCE_I  = 3'd1,
    KIND_FENCE_T  = 3'd2,
    KIND_SFENCE   = 3'd3,
    KIND_HFENCE_V = 3'd4,
    KIND_HFENCE_G = 3'd5
  } flush_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_DFLUSH = 3'd2,
    ST_IFLUSH = 3'd3,
    ST_TLB    = 3'd4,
    ST_DONE   = 3'd5
  } flush_state_e;

  function automatic int timer_width(input int drain_timeout);
    return $clog2(drain_timeout);
  endfunction

  // Unused encodings fold to FENCE; hypervisor fences fold to SFENCE without RVH.
  function automatic flush_kind_e map_kind(input logic [2:0] raw, input bit rvh);
    flush_kind_e k;
    case (raw)
      3'd1:    k = KIND_FENCE_I;
      3'd2:    k = KIND_FENCE_T;
      3'd3:    k = KIND_SFENCE;
      3'd4:    k = rvh ? KIND_HFENCE_V : KIND_SFENCE;
      3'd5:    k = rvh ? KIND_HFENCE_G : KIND_SFENCE;
      default: k = KIND_FENCE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/flush_drain_timer.sv
// Saturating drain-wait counter with a sticky flag raised when the count reaches MAX_COUNT.
module flush_drain_timer #(
  parameter int WIDTH     = 10,
  parameter int MAX_COUNT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_r;
  logic             expired_r;

  // Count while enabled, hold at MAX_VAL; the flag is set on the step that lands on MAX_VAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r   <= '0;
      expired_r <= 1'b0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != MAX_VAL)) begin
      count_r <= count_r + WIDTH'(1);
      if (count_r == (MAX_VAL - WIDTH'(1))) begin
        expired_r <= 1'b1;
      end
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/commit_flush_sequencer.sv
// Sequences commit-stage fences: store drain, D$ flush handshake, I$/TLB pulses, pipeline flush.
// Optional performance counters are built when FLUSH_SEQ_PERF_EN is defined.
module commit_flush_sequencer
  import flush_seq_pkg::*;
#(
  parameter bit DCACHE_WB     = 1'b1,
  parameter bit RVH           = 1'b1,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic [2:0]  req_kind_i,
  output logic        req_ready_o,
  input  logic        halt_i,
  input  logic        no_st_pending_i,
  output logic        dcache_flush_o,
  input  logic        dcache_flush_ack_i,
  output logic        icache_flush_o,
  output logic        sfence_vma_o,
  output logic        hfence_vvma_o,
  output logic        hfence_gvma_o,
  output logic        flush_pipeline_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        drain_timeout_o,
  output logic [31:0] drain_cycles_o,
  output logic [31:0] dflush_cycles_o
);

  localparam int TW = timer_width(DRAIN_TIMEOUT);

  flush_state_e state_r, state_next_s;
  flush_kind_e  kind_r;
  logic         accept_s;
  logic         dcache_flush_r, icache_flush_r, sfence_r, hvvma_r, hgvma_r, done_r, busy_r;

  assign accept_s    = (state_r == ST_IDLE) && req_valid_i && !halt_i;
  assign req_ready_o = (state_r == ST_IDLE) && !halt_i && !rst_i;

  flush_drain_timer #(
    .WIDTH     (TW),
    .MAX_COUNT (DRAIN_TIMEOUT - 1)
  ) u_drain_timer (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (accept_s),
    .enable  ((state_r == ST_DRAIN) && !no_st_pending_i),
    .expired (drain_timeout_o)
  );

  // State and latched kind.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      kind_r  <= KIND_FENCE;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        kind_r <= map_kind(req_kind_i, RVH);
      end
    end
  end

  // Next-state selection.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_DRAIN;
        else          state_next_s = ST_IDLE;
      end
      ST_DRAIN: begin
        if (no_st_pending_i) begin
          case (kind_r)
            KIND_FENCE:                 state_next_s = DCACHE_WB ? ST_DFLUSH : ST_DONE;
            KIND_FENCE_I, KIND_FENCE_T: state_next_s = DCACHE_WB ? ST_DFLUSH : ST_IFLUSH;
            default:                    state_next_s = ST_TLB;
          endcase
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DFLUSH: begin
        if (dcache_flush_ack_i) state_next_s = (kind_r == KIND_FENCE) ? ST_DONE : ST_IFLUSH;
        else                    state_next_s = ST_DFLUSH;
      end
      ST_IFLUSH: state_next_s = (kind_r == KIND_FENCE_T) ? ST_TLB : ST_DONE;
      ST_TLB:    state_next_s = ST_DONE;
      ST_DONE:   state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Outputs are flopped decodes of the upcoming state so they line up with state_r.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dcache_flush_r <= 1'b0;
      icache_flush_r <= 1'b0;
      sfence_r       <= 1'b0;
      hvvma_r        <= 1'b0;
      hgvma_r        <= 1'b0;
      done_r         <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      dcache_flush_r <= (state_next_s == ST_DFLUSH);
      icache_flush_r <= (state_next_s == ST_IFLUSH);
      sfence_r       <= (state_next_s == ST_TLB) &&
                        ((kind_r == KIND_SFENCE) || (kind_r == KIND_FENCE_T));
      hvvma_r        <= (state_next_s == ST_TLB) && (kind_r == KIND_HFENCE_V);
      hgvma_r        <= (state_next_s == ST_TLB) && (kind_r == KIND_HFENCE_G);
      done_r         <= (state_next_s == ST_DONE);
      busy_r         <= (state_next_s != ST_IDLE);
    end
  end

  assign dcache_flush_o   = dcache_flush_r;
  assign icache_flush_o   = icache_flush_r;
  assign sfence_vma_o     = sfence_r;
  assign hfence_vvma_o    = hvvma_r;
  assign hfence_gvma_o    = hgvma_r;
  assign flush_pipeline_o = done_r;
  assign done_o           = done_r;
  assign busy_o           = busy_r;

`ifdef FLUSH_SEQ_PERF_EN
  logic [31:0] drain_cycles_r, dflush_cycles_r;

  // Residency counters; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drain_cycles_r  <= 32'd0;
      dflush_cycles_r <= 32'd0;
    end else begin
      if (state_r == ST_DRAIN)  drain_cycles_r  <= drain_cycles_r + 32'd1;
      if (state_r == ST_DFLUSH) dflush_cycles_r <= dflush_cycles_r + 32'd1;
    end
  end

  assign drain_cycles_o  = drain_cycles_r;
  assign dflush_cycles_o = dflush_cycles_r;
`else
  assign drain_cycles_o  = 32'd0;
  assign dflush_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_commit_flush_sequencer.sv
// Randomized bench for commit_flush_sequencer: two configurations checked against a
// per-transaction model that expands each fence kind into its expected step list.
module tb_commit_flush_sequencer;

  localparam bit WB0 = 1'b1, RVH0 = 1'b1;
  localparam int TO0 = 8;
  localparam bit WB1 = 1'b0, RVH1 = 1'b0;
  localparam int TO1 = 4;

  // step codes used by the model
  localparam int S_IDLE = 0, S_DRAIN = 1, S_DFL = 2, S_IFL = 3, S_SF = 4, S_HV = 5, S_HG = 6, S_DONE = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, no_st, ack;
  logic [2:0]  req_kind;
  logic        halt;
  logic [1:0]  ready, dflush, iflush, sfence, hvvma, hgvma, fpipe, done, busy, tmo;
  logic [31:0] dcyc0, dcyc1, fcyc0, fcyc1;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          sticky [2];
  logic [31:0] exp_dc [2];
  logic [31:0] exp_fc [2];

  always #5 clk = ~clk;

  commit_flush_sequencer #(.DCACHE_WB(WB0), .RVH(RVH0), .DRAIN_TIMEOUT(TO0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_kind_i(req_kind),
    .req_ready_o(ready[0]), .halt_i(halt), .no_st_pending_i(no_st[0]),
    .dcache_flush_o(dflush[0]), .dcache_flush_ack_i(ack[0]), .icache_flush_o(iflush[0]),
    .sfence_vma_o(sfence[0]), .hfence_vvma_o(hvvma[0]), .hfence_gvma_o(hgvma[0]),
    .flush_pipeline_o(fpipe[0]), .done_o(done[0]), .busy_o(busy[0]),
    .drain_timeout_o(tmo[0]), .drain_cycles_o(dcyc0), .dflush_cycles_o(fcyc0));

  commit_flush_sequencer #(.DCACHE_WB(WB1), .RVH(RVH1), .DRAIN_TIMEOUT(TO1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_kind_i(req_kind),
    .req_ready_o(ready[1]), .halt_i(halt), .no_st_pending_i(no_st[1]),
    .dcache_flush_o(dflush[1]), .dcache_flush_ack_i(ack[1]), .icache_flush_o(iflush[1]),
    .sfence_vma_o(sfence[1]), .hfence_vvma_o(hvvma[1]), .hfence_gvma_o(hgvma[1]),
    .flush_pipeline_o(fpipe[1]), .done_o(done[1]), .busy_o(busy[1]),
    .drain_timeout_o(tmo[1]), .drain_cycles_o(dcyc1), .dflush_cycles_o(fcyc1));

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] outs(input int d);
    return {ready[d], busy[d], dflush[d], iflush[d], sfence[d], hvvma[d], hgvma[d],
            fpipe[d], done[d], tmo[d]};
  endfunction

  function automatic logic [9:0] expect_vec(input bit rdy, input int step, input bit tmo_e);
    logic [9:0] v;
    v    = 10'd0;
    v[9] = rdy;
    v[8] = (step != S_IDLE);
    v[7] = (step == S_DFL);
    v[6] = (step == S_IFL);
    v[5] = (step == S_SF);
    v[4] = (step == S_HV);
    v[3] = (step == S_HG);
    v[2] = (step == S_DONE);
    v[1] = (step == S_DONE);
    v[0] = tmo_e;
    return v;
  endfunction

  // Set inputs for one cycle (other DUT idle with noise on its handshakes), then settle.
  task automatic drive_cycle(input int d, input bit v, input logic [2:0] k, input bit h,
                             input bit ns, input bit a);
    @(negedge clk);
    req_valid   = 2'b00;
    req_valid[d] = v;
    no_st       = 2'($urandom);
    no_st[d]    = ns;
    ack         = 2'($urandom);
    ack[d]      = a;
    req_kind    = k;
    halt        = h;
    #1;
  endtask

  task automatic check_perf(input int d);
    logic [31:0] ed, ef;
`ifdef FLUSH_SEQ_PERF_EN
    ed = exp_dc[d];
    ef = exp_fc[d];
`else
    ed = 32'd0;
    ef = 32'd0;
`endif
    check_value("drain_cycles", (d == 0) ? dcyc0 : dcyc1, ed);
    check_value("dflush_cycles", (d == 0) ? fcyc0 : fcyc1, ef);
  endtask

  // One complete fence request on DUT d, expanded into its step list by kind rules.
  task automatic run_txn(input int d, input logic [2:0] raw, input int drain_len,
                         input int ack_delay, input int halt_pre);
    bit wb, rvh;
    int to, eff;
    wb  = (d == 0) ? WB0 : WB1;
    rvh = (d == 0) ? RVH0 : RVH1;
    to  = (d == 0) ? TO0 : TO1;
    eff = (raw >= 3'd6) ? 0 : int'(raw);
    if (!rvh && eff >= 4) eff = 3;

    for (int i = 0; i < halt_pre; i++) begin
      drive_cycle(d, 1'b1, raw, 1'b1, 1'($urandom), 1'b0);
      check_value("halt_blocks", 32'(outs(d)), 32'(expect_vec(1'b0, S_IDLE, sticky[d])));
    end
    drive_cycle(d, 1'b1, raw, 1'b0, 1'($urandom), 1'($urandom));
    check_value("accept", 32'(outs(d)), 32'(expect_vec(1'b1, S_IDLE, sticky[d])));

    for (int i = 0; i <= drain_len; i++) begin
      drive_cycle(d, 1'b1, 3'($urandom), 1'($urandom), (i == drain_len), 1'($urandom));
      check_value("drain", 32'(outs(d)), 32'(expect_vec(1'b0, S_DRAIN, sticky[d] || (i >= to - 1))));
    end
    if (drain_len >= to - 1) sticky[d] = 1'b1;
    exp_dc[d] += 32'(drain_len + 1);

    if (wb && eff <= 2) begin
      for (int i = 0; i <= ack_delay; i++) begin
        drive_cycle(d, 1'b1, 3'($urandom), 1'($urandom), 1'($urandom), (i == ack_delay));
        check_value("dflush", 32'(outs(d)), 32'(expect_vec(1'b0, S_DFL, sticky[d])));
      end
      exp_fc[d] += 32'(ack_delay + 1);
    end
    if (eff == 1 || eff == 2) begin
      drive_cycle(d, 1'b1, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      check_value("iflush", 32'(outs(d)), 32'(expect_vec(1'b0, S_IFL, sticky[d])));
    end
    if (eff >= 2) begin
      drive_cycle(d, 1'b1, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      check_value("tlb", 32'(outs(d)),
                  32'(expect_vec(1'b0, (eff == 4) ? S_HV : (eff == 5) ? S_HG : S_SF, sticky[d])));
    end
    drive_cycle(d, 1'b1, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    check_value("done", 32'(outs(d)), 32'(expect_vec(1'b0, S_DONE, sticky[d])));
    check_perf(d);
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; no_st = 2'b00; ack = 2'b00; req_kind = 3'd0; halt = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sticky[d] = 1'b0; exp_dc[d] = 32'd0; exp_fc[d] = 32'd0;
    end
    repeat (3) @(negedge clk);
    #1;
    check_value("reset_outs0", 32'(outs(0)), 32'd0);
    check_value("reset_outs1", 32'(outs(1)), 32'd0);
    check_perf(0);
    check_perf(1);
    rst = 1'b0;

    run_txn(0, 3'd0, 0, 4, 0);   // FENCE, ack on 5th D$ flush cycle
    run_txn(0, 3'd1, 10, 2, 1);  // FENCE_I, long drain crosses timeout
    run_txn(1, 3'd3, 9, 0, 0);   // SFENCE, drain timeout with small limit
    run_txn(1, 3'd2, 0, 0, 0);   // FENCE_T without write-back D$
    run_txn(1, 3'd5, 0, 0, 2);   // HFENCE_G folds to SFENCE
    run_txn(1, 3'd0, 1, 0, 0);   // FENCE straight to done
    run_txn(0, 3'd7, 2, 0, 0);   // unused encoding acts as FENCE
    run_txn(0, 3'd2, 0, 1, 0);
    run_txn(0, 3'd4, 0, 0, 0);
    run_txn(0, 3'd5, 3, 0, 0);
    run_txn(0, 3'd3, 0, 0, 0);

    // Reset while D$ flush is pending, then a stray ack must not wake the FSM.
    drive_cycle(0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
    check_value("rst_accept", 32'(outs(0)), 32'(expect_vec(1'b1, S_IDLE, sticky[0])));
    drive_cycle(0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
    check_value("rst_drain", 32'(outs(0)), 32'(expect_vec(1'b0, S_DRAIN, sticky[0])));
    drive_cycle(0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
    check_value("rst_dflush", 32'(outs(0)), 32'(expect_vec(1'b0, S_DFL, sticky[0])));
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b00; ack = 2'b00;
    @(negedge clk);
    #1;
    check_value("rst_mid_op", 32'(outs(0)), 32'd0);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sticky[d] = 1'b0; exp_dc[d] = 32'd0; exp_fc[d] = 32'd0;
    end
    drive_cycle(0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    check_value("stray_ack", 32'(outs(0)), 32'(expect_vec(1'b1, S_IDLE, 1'b0)));
    drive_cycle(0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    check_value("stray_ack_idle", 32'(outs(0)), 32'(expect_vec(1'b1, S_IDLE, 1'b0)));
    check_perf(0);

    for (int n = 0; n < 80; n++) begin
      run_txn($urandom_range(0, 1), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 2),
              $urandom_range(0, 6), $urandom_range(0, 2));
    end
    check_perf(0);
    check_perf(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
